simon_engine: RTL and testbench
===============================

Name: simon_engine

Overview:
- Self-contained Simon game engine: FSM plus sequence memory, index/length counters, playback step timer and retry counter in one block.
- Generalises the four-state Simon controller: parametrised pattern width, sequence depth and playback pacing, plus configurable retries, a WIN terminal state and a restart command.
- Sits between the debounced switch/button front end and the board LEDs.

Parameters:
- PATTERN_W, 4: pattern width and LED count. Must be >= 2.
- DEPTH, 16: maximum sequence length. Must be >= 1.
- STEP_CYCLES, 1: clock cycles each playback/done pattern is shown. Must be >= 1.
- MAX_RETRIES, 0: repeat mistakes tolerated before DONE. 0 gives classic behaviour.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pattern_in  in  PATTERN_W  player switch pattern.
- submit  in  1  one-cycle pulse: sample pattern_in this cycle.
- restart  in  1  one-cycle pulse: start a new game from DONE or WIN.
- pattern_leds  out  PATTERN_W  pattern LED drive.
- mode_leds  out  3  mode indicator.
- level  out  $clog2(DEPTH+1)  current sequence length n.
- retries_left  out  $clog2(MAX_RETRIES+1) (min 1)  remaining retries.

Behaviour:
- Valid pattern: pattern_in has exactly one bit set.
- Internal state: mem[DEPTH] of PATTERN_W (not reset); n (0..DEPTH); i (0..DEPTH-1); tick (0..STEP_CYCLES-1); state.
- Reset while rst=0, asynchronous, any cycle including mid-playback: state=INPUT, n=0, i=0, tick=0, retries_left=MAX_RETRIES.
  - Outputs during reset: mode_leds=001, level=0, pattern_leds=pattern_in.
- mode_leds (decoded from registered state): INPUT=001, PLAYBACK=010, REPEAT=100, DONE=111, WIN=101.
- pattern_leds (combinational):
  - INPUT, REPEAT: pattern_in.
  - PLAYBACK, DONE: mem[i].
  - WIN: all ones.
- INPUT:
  - submit with a valid pattern: mem[n] <= pattern_in, n <= n+1, i <= 0, tick <= 0, next state PLAYBACK.
  - submit with an invalid pattern: ignored, no state change.
  - INPUT is only ever entered with n < DEPTH.
- PLAYBACK:
  - tick increments every cycle.
  - When tick == STEP_CYCLES-1: tick <= 0. If i == n-1, then i <= 0 and go to REPEAT; otherwise i <= i+1.
  - submit is ignored.
  - Each entry shows exactly n patterns for STEP_CYCLES cycles each, so dwell is n*STEP_CYCLES cycles.
- REPEAT: acts only on submit; validity is not checked, only equality with mem[i].
  - Match, i < n-1: i <= i+1.
  - Match, i == n-1: i <= 0. Go to WIN if n == DEPTH, else INPUT.
  - Mismatch, retries_left > 0: retries_left <= retries_left-1, i <= 0, tick <= 0, go to PLAYBACK (replays the same sequence; n unchanged).
  - Mismatch, retries_left == 0: i <= 0, tick <= 0, go to DONE.
- DONE:
  - Loops i over 0..n-1 with the same tick pacing, wrapping n-1 -> 0.
  - submit is ignored.
- WIN: holds; submit is ignored.
- restart: honoured only in DONE/WIN. Sets n=0, i=0, tick=0, retries_left=MAX_RETRIES, state=INPUT. Ignored in all other states.
- Retries are not refilled between rounds; only reset or restart refills them.
- Counters never wrap beyond their ranges. n saturates at DEPTH by construction.

Test Plan:
- Reset mid-PLAYBACK, then release -> mode_leds=001, level=0, retries_left=MAX_RETRIES immediately.
- DEPTH=16, STEP_CYCLES=1, MAX_RETRIES=0: submit 0001 in INPUT -> 1 cycle PLAYBACK with pattern_leds=0001, then REPEAT (100). Submit 0001 -> INPUT, level=1.
- Submit 0011 in INPUT -> ignored, stays INPUT, level unchanged. Submit 0100 in PLAYBACK -> ignored.
- STEP_CYCLES=3, sequence 0001,0010: PLAYBACK shows 0001 for 3 cycles, then 0010 for 3 cycles, then REPEAT. Submit 0010 first -> DONE (111); pattern_leds cycles 0001,0010 every 3 cycles.
- MAX_RETRIES=1, sequence of 3: wrong second entry -> retries_left=0, PLAYBACK replays all 3. Second mistake -> DONE. restart pulse -> INPUT, level=0, retries_left=1.
- DEPTH=2: two complete correct rounds -> WIN (mode_leds=101, pattern_leds=1111). submit ignored. restart -> INPUT.

Source files
------------

// File: rtl/simon_engine.sv
// simon_engine: Simon game controller with sequence memory, playback pacing,
// retry budget, a WIN terminal state and a restart command.
// The player's switch pattern is appended to the sequence in INPUT, the whole
// sequence is replayed in PLAYBACK, and the player must echo it in REPEAT.
module simon_engine #(
  parameter  int PATTERN_W   = 4,
  parameter  int DEPTH       = 16,
  parameter  int STEP_CYCLES = 1,
  parameter  int MAX_RETRIES = 0,
  localparam int LVL_W       = $clog2(DEPTH + 1),
  localparam int RET_W       = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PATTERN_W-1:0] pattern_in,
  input  logic                 submit,
  input  logic                 restart,
  output logic [PATTERN_W-1:0] pattern_leds,
  output logic [2:0]           mode_leds,
  output logic [LVL_W-1:0]     level,
  output logic [RET_W-1:0]     retries_left
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TICK_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_CYCLES - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
  localparam logic [RET_W-1:0]  RET_INIT  = RET_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_INPUT,
    S_PLAYBACK,
    S_REPEAT,
    S_DONE,
    S_WIN
  } state_t;

  state_t               state;
  logic [PATTERN_W-1:0] mem [DEPTH];
  logic [LVL_W-1:0]     n;
  logic [IDX_W-1:0]     i;
  logic [TICK_W-1:0]    tick;

  logic                 pattern_valid;
  logic                 load_pattern;
  logic                 tick_last;
  logic                 i_last;
  logic                 seq_full;
  logic [PATTERN_W-1:0] mem_at_i;

  // A player pattern is only meaningful when exactly one switch is up.
  assign pattern_valid = $onehot(pattern_in);
  assign load_pattern  = (state == S_INPUT) && submit && pattern_valid;

  // i and n are compared in n's width; n is at least 1 whenever i_last is used.
  assign tick_last = (tick == TICK_LAST);
  assign i_last    = (LVL_W'(i) == (n - LVL_ONE));
  assign seq_full  = (n == LVL_FULL);
  assign mem_at_i  = mem[i];

  assign level = n;

  // Sequence memory holds the game history and deliberately has no reset.
  always_ff @(posedge clk) begin
    if (load_pattern) begin
      mem[n[IDX_W-1:0]] <= pattern_in;
    end
  end

  // Game FSM: owns state, sequence length, index, step timer and retries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_INPUT;
      n            <= '0;
      i            <= '0;
      tick         <= '0;
      retries_left <= RET_INIT;
    end else begin
      case (state)
        S_INPUT: begin
          if (load_pattern) begin
            n     <= n + LVL_ONE;
            i     <= '0;
            tick  <= '0;
            state <= S_PLAYBACK;
          end
        end

        S_PLAYBACK: begin
          if (tick_last) begin
            tick <= '0;
            if (i_last) begin
              i     <= '0;
              state <= S_REPEAT;
            end else begin
              i <= i + 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end

        S_REPEAT: begin
          if (submit) begin
            if (pattern_in == mem_at_i) begin
              if (i_last) begin
                i     <= '0;
                state <= seq_full ? S_WIN : S_INPUT;
              end else begin
                i <= i + 1'b1;
              end
            end else begin
              i    <= '0;
              tick <= '0;
              if (retries_left != '0) begin
                retries_left <= retries_left - 1'b1;
                state        <= S_PLAYBACK;
              end else begin
                state <= S_DONE;
              end
            end
          end
        end

        S_DONE: begin
          if (restart) begin
            state        <= S_INPUT;
            n            <= '0;
            i            <= '0;
            tick         <= '0;
            retries_left <= RET_INIT;
          end else if (tick_last) begin
            tick <= '0;
            i    <= i_last ? '0 : i + 1'b1;
          end else begin
            tick <= tick + 1'b1;
          end
        end

        S_WIN: begin
          if (restart) begin
            state        <= S_INPUT;
            n            <= '0;
            i            <= '0;
            tick         <= '0;
            retries_left <= RET_INIT;
          end
        end

        default: begin
          state <= S_INPUT;
        end
      endcase
    end
  end

  // Mode indicator is a pure decode of the registered state.
  always_comb begin
    mode_leds = 3'b001;
    case (state)
      S_INPUT:    mode_leds = 3'b001;
      S_PLAYBACK: mode_leds = 3'b010;
      S_REPEAT:   mode_leds = 3'b100;
      S_DONE:     mode_leds = 3'b111;
      S_WIN:      mode_leds = 3'b101;
      default:    mode_leds = 3'b001;
    endcase
  end

  // Pattern LEDs echo the switches while the player acts, else show the sequence.
  always_comb begin
    pattern_leds = pattern_in;
    case (state)
      S_INPUT, S_REPEAT:  pattern_leds = pattern_in;
      S_PLAYBACK, S_DONE: pattern_leds = mem_at_i;
      S_WIN:              pattern_leds = '1;
      default:            pattern_leds = pattern_in;
    endcase
  end

endmodule

// File: tb/tb_simon_engine.sv
// tb_simon_engine: directed scenarios plus randomized play against a
// queue-based behavioural model of the Simon game.
module tb_simon_engine;

  localparam int PW    = 4;
  localparam int DEPTH = 4;
  localparam int STEP  = 3;
  localparam int RETR  = 1;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int RET_W = (RETR > 0) ? $clog2(RETR + 1) : 1;

  localparam logic [2:0] M_INPUT  = 3'b001;
  localparam logic [2:0] M_PLAY   = 3'b010;
  localparam logic [2:0] M_REPEAT = 3'b100;
  localparam logic [2:0] M_DONE   = 3'b111;
  localparam logic [2:0] M_WIN    = 3'b101;

  logic             clk;
  logic             rst;
  logic [PW-1:0]    pattern_in;
  logic             submit;
  logic             restart;
  logic [PW-1:0]    pattern_leds;
  logic [2:0]       mode_leds;
  logic [LVL_W-1:0] level;
  logic [RET_W-1:0] retries_left;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: the game as a list of patterns plus a playback queue.
  logic [PW-1:0] m_seq[$];
  logic [PW-1:0] m_show[$];
  logic [2:0]    m_mode;
  int            m_pos;
  int            m_done_cnt;
  int            m_retries;

  simon_engine #(
    .PATTERN_W  (PW),
    .DEPTH      (DEPTH),
    .STEP_CYCLES(STEP),
    .MAX_RETRIES(RETR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pattern_in  (pattern_in),
    .submit      (submit),
    .restart     (restart),
    .pattern_leds(pattern_leds),
    .mode_leds   (mode_leds),
    .level       (level),
    .retries_left(retries_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_seq.delete();
    m_show.delete();
    m_mode     = M_INPUT;
    m_pos      = 0;
    m_done_cnt = 0;
    m_retries  = RETR;
  endtask

  // Playback shows every stored pattern for STEP cycles, in order.
  task automatic load_show();
    m_show.delete();
    foreach (m_seq[k]) begin
      for (int r = 0; r < STEP; r++) m_show.push_back(m_seq[k]);
    end
  endtask

  function automatic logic [PW-1:0] exp_leds();
    case (m_mode)
      M_PLAY:  return m_show[0];
      M_DONE:  return m_seq[(m_done_cnt / STEP) % m_seq.size()];
      M_WIN:   return '1;
      default: return pattern_in;
    endcase
  endfunction

  // Model advances on the same edges as the design, with an async reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_reset();
    end else begin
      case (m_mode)
        M_INPUT: begin
          if (submit && $countones(pattern_in) == 1) begin
            m_seq.push_back(pattern_in);
            load_show();
            m_mode = M_PLAY;
          end
        end
        M_PLAY: begin
          m_show.delete(0);
          if (m_show.size() == 0) begin
            m_mode = M_REPEAT;
            m_pos  = 0;
          end
        end
        M_REPEAT: begin
          if (submit) begin
            if (pattern_in == m_seq[m_pos]) begin
              m_pos++;
              if (m_pos == m_seq.size()) m_mode = (m_seq.size() == DEPTH) ? M_WIN : M_INPUT;
            end else if (m_retries > 0) begin
              m_retries--;
              load_show();
              m_mode = M_PLAY;
            end else begin
              m_mode     = M_DONE;
              m_done_cnt = 0;
            end
          end
        end
        M_DONE: begin
          if (restart) model_reset();
          else m_done_cnt++;
        end
        M_WIN: begin
          if (restart) model_reset();
        end
        default: model_reset();
      endcase
    end
  end

  // Every cycle, all outputs are compared with the model away from the edge.
  always @(negedge clk) begin
    checkOutput("mode_leds", mode_leds, m_mode);
    checkOutput("level", level, m_seq.size());
    checkOutput("retries_left", retries_left, m_retries);
    checkOutput("pattern_leds", pattern_leds, exp_leds());
  end

  // Drive one cycle of inputs; returns just after the edge that consumed them.
  task automatic applyStimulus(input logic [PW-1:0] pat, input logic sub, input logic rs);
    pattern_in = pat;
    submit     = sub;
    restart    = rs;
    @(posedge clk);
    #2;
    submit  = 1'b0;
    restart = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_mode(input logic [2:0] target, input int budget);
    int cnt;
    cnt = 0;
    while (m_mode != target && cnt < budget) begin
      idle(1);
      cnt++;
    end
    if (m_mode != target) checkOutput("wait_mode", m_mode, target);
  endtask

  task automatic play_round(input logic [PW-1:0] pat);
    int len;
    applyStimulus(pat, 1'b1, 1'b0);
    wait_mode(M_REPEAT, 64);
    len = m_seq.size();
    for (int k = 0; k < len; k++) applyStimulus(m_seq[k], 1'b1, 1'b0);
  endtask

  logic [PW-1:0] r_pat;
  logic          r_sub;
  logic          r_rs;

  initial begin
    rst        = 1'b0;
    pattern_in = 4'b1010;
    submit     = 1'b0;
    restart    = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("rst_mode", mode_leds, 3'b001);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_retries", retries_left, 1);
    checkOutput("rst_leds", pattern_leds, 4'b1010);
    idle(1);
    rst = 1'b1;

    applyStimulus(4'b0011, 1'b1, 1'b0);
    checkOutput("invalid_mode", mode_leds, 3'b001);
    checkOutput("invalid_level", level, 0);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    checkOutput("r1_mode", mode_leds, 3'b010);
    checkOutput("r1_level", level, 1);
    checkOutput("r1_leds", pattern_leds, 4'b0001);
    applyStimulus(4'b0100, 1'b1, 1'b0);
    checkOutput("play_sub_mode", mode_leds, 3'b010);
    checkOutput("play_sub_leds", pattern_leds, 4'b0001);
    idle(1);
    checkOutput("play_c3_mode", mode_leds, 3'b010);
    idle(1);
    checkOutput("repeat_mode", mode_leds, 3'b100);
    checkOutput("repeat_leds", pattern_leds, 4'b0100);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    checkOutput("r1_ok_mode", mode_leds, 3'b001);
    checkOutput("r1_ok_level", level, 1);

    applyStimulus(4'b0010, 1'b1, 1'b0);
    checkOutput("r2_level", level, 2);
    checkOutput("r2_leds0", pattern_leds, 4'b0001);
    idle(2);
    checkOutput("r2_leds0_end", pattern_leds, 4'b0001);
    idle(1);
    checkOutput("r2_leds1", pattern_leds, 4'b0010);
    idle(2);
    checkOutput("r2_leds1_end", pattern_leds, 4'b0010);
    idle(1);
    checkOutput("r2_repeat", mode_leds, 3'b100);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    checkOutput("r2_match0", mode_leds, 3'b100);
    applyStimulus(4'b0100, 1'b1, 1'b0);
    checkOutput("retry_mode", mode_leds, 3'b010);
    checkOutput("retry_left", retries_left, 0);
    checkOutput("retry_leds", pattern_leds, 4'b0001);
    idle(6);
    checkOutput("retry_repeat", mode_leds, 3'b100);
    applyStimulus(4'b0010, 1'b1, 1'b0);
    checkOutput("done_mode", mode_leds, 3'b111);
    checkOutput("done_leds0", pattern_leds, 4'b0001);
    idle(2);
    checkOutput("done_leds0_end", pattern_leds, 4'b0001);
    idle(1);
    checkOutput("done_leds1", pattern_leds, 4'b0010);
    idle(3);
    checkOutput("done_wrap", pattern_leds, 4'b0001);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    checkOutput("done_sub_ignored", mode_leds, 3'b111);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("restart_mode", mode_leds, 3'b001);
    checkOutput("restart_level", level, 0);
    checkOutput("restart_retries", retries_left, 1);

    play_round(4'b0001);
    play_round(4'b0100);
    play_round(4'b1000);
    play_round(4'b0010);
    checkOutput("win_mode", mode_leds, 3'b101);
    checkOutput("win_leds", pattern_leds, 4'b1111);
    checkOutput("win_level", level, 4);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    checkOutput("win_sub_ignored", mode_leds, 3'b101);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("win_restart_mode", mode_leds, 3'b001);
    checkOutput("win_restart_level", level, 0);

    applyStimulus(4'b1000, 1'b1, 1'b0);
    applyStimulus(4'b1000, 1'b0, 1'b1);
    checkOutput("play_restart_ignored", mode_leds, 3'b010);
    wait_mode(M_REPEAT, 16);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    checkOutput("mid_retry_left", retries_left, 0);
    idle(1);
    rst = 1'b0;
    #1;
    checkOutput("midrst_mode", mode_leds, 3'b001);
    checkOutput("midrst_level", level, 0);
    checkOutput("midrst_retries", retries_left, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    idle(1);
    checkOutput("post_rst_mode", mode_leds, 3'b001);

    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
      end else begin
        r_pat = PW'($urandom_range(0, 15));
        r_sub = 1'b0;
        r_rs  = ($urandom_range(0, 15) == 0);
        case (m_mode)
          M_INPUT: begin
            r_sub = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 9) < 7) r_pat = PW'(1 << $urandom_range(0, PW - 1));
          end
          M_REPEAT: begin
            r_sub = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) != 0) r_pat = m_seq[m_pos];
          end
          default: begin
            r_sub = ($urandom_range(0, 9) == 0);
            r_rs  = ($urandom_range(0, 7) == 0);
          end
        endcase
        applyStimulus(r_pat, r_sub, r_rs);
      end
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
